// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master arbiter in front of the single data-memory port.
// Master 0 (CPU load/store) has fixed priority. Master 1 (debug/loader)
// wins a contest once STARVE_MAX consecutive contests have gone to master 0.
// Optional grant/contest statistics outputs: define DMEM_ARB_STATS_EN.
//
// state | meaning
// IDLE  | no access in flight, arbitrating
// BUSY0 | access for master 0 outstanding on the memory port
// BUSY1 | access for master 1 outstanding on the memory port
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wmask,
  output logic                m0_ack,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wmask,
  output logic                m1_ack,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]         gnt0_cnt,
  output logic [31:0]         gnt1_cnt,
  output logic [15:0]         contest_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       vld0, vld1;
  logic       gnt0, gnt1, contest;

  // A master whose ack is high this cycle is still holding req from the
  // finished access, so it is not a new request.
  assign vld0 = m0_req && !m0_ack;
  assign vld1 = m1_req && !m1_ack;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Arbitration and next-state decode.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    contest   = 1'b0;
    case (state)
      IDLE: begin
        contest = vld0 && vld1;
        if (contest) begin
          if (starve_cnt == STARVE_LIM) gnt1 = 1'b1;
          else                          gnt0 = 1'b1;
        end else if (vld0) begin
          gnt0 = 1'b1;
        end else if (vld1) begin
          gnt1 = 1'b1;
        end
        if (gnt0) state_nxt = BUSY0;
        if (gnt1) state_nxt = BUSY1;
      end
      BUSY0, BUSY1: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-port registers, acks and returned read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      if (gnt0) begin
        mem_req   <= 1'b1;
        mem_we    <= m0_we;
        mem_addr  <= m0_addr;
        mem_wdata <= m0_wdata;
        mem_wmask <= m0_wmask;
      end else if (gnt1) begin
        mem_req   <= 1'b1;
        mem_we    <= m1_we;
        mem_addr  <= m1_addr;
        mem_wdata <= m1_wdata;
        mem_wmask <= m1_wmask;
      end
      if (state == BUSY0 && mem_ready) begin
        mem_req <= 1'b0;
        m0_ack  <= 1'b1;
        if (!mem_we) m0_rdata <= mem_rdata;
      end
      if (state == BUSY1 && mem_ready) begin
        mem_req <= 1'b0;
        m1_ack  <= 1'b1;
        if (!mem_we) m1_rdata <= mem_rdata;
      end
    end
  end

  // Starvation guard: counts contests master 0 has won in a row.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (gnt1) begin
      starve_cnt <= '0;
    end else if (gnt0 && contest && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  // Grant and contest statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt0_cnt    <= '0;
      gnt1_cnt    <= '0;
      contest_cnt <= '0;
    end else begin
      if (gnt0) gnt0_cnt <= gnt0_cnt + 32'd1;
      if (gnt1) gnt1_cnt <= gnt1_cnt + 32'd1;
      if (contest && contest_cnt != 16'hFFFF) contest_cnt <= contest_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter (default parameters).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] gnt0_cnt, gnt1_cnt;
  logic [15:0] contest_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wmask(m0_wmask), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wmask(m1_wmask), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef DMEM_ARB_STATS_EN
    , .gnt0_cnt(gnt0_cnt), .gnt1_cnt(gnt1_cnt), .contest_cnt(contest_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 0 = contest (both request), 1 = master 0 alone
  logic [10:0] rnd_solo = 11'b000_0000_0100;
  // expected winner per round: 1 = master 1
  logic [10:0] rnd_win1 = 11'b100_0010_0000;

  initial begin
    rst = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
    mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
    step(); step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_acks", {m0_ack, m1_ack}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    rst = 1'b1;
    step();

    // single read by master 0
    m0_req = 1; m0_we = 0; m0_addr = 32'h10;
    step();
    chk("rd_mem_req", mem_req, 1);
    chk("rd_mem_addr", mem_addr, 32'h10);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_ack_early", m0_ack, 0);
    step();
    chk("rd_mem_req_drop", mem_req, 0);
    chk("rd_ack", m0_ack, 1);
    chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    m0_req = 0;
    step();
    chk("rd_ack_pulse", m0_ack, 0);
    chk("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);

    // write by master 1
    m1_req = 1; m1_we = 1; m1_addr = 32'h4; m1_wdata = 32'h000000FF; m1_wmask = 4'b0001;
    step();
    chk("wr_mem_req", mem_req, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 32'h4);
    chk("wr_mem_wdata", mem_wdata, 32'hFF);
    chk("wr_mem_wmask", mem_wmask, 4'b0001);
    step();
    chk("wr_ack", m1_ack, 1);
    chk("wr_rdata_kept", m1_rdata, 0);
    chk("wr_m0_no_ack", m0_ack, 0);
    m1_req = 0; m1_we = 0;
    step();
    chk("wr_ack_pulse", m1_ack, 0);
    chk("idle_addr_hold", mem_addr, 32'h4);
    chk("idle_wdata_hold", mem_wdata, 32'hFF);

    // memory stalls for 5 cycles
    mem_ready = 0;
    m0_req = 1; m0_addr = 32'h20;
    step();
    chk("stall_req_0", mem_req, 1);
    for (int i = 1; i < 6; i++) begin
      step();
      chk($sformatf("stall_req_%0d", i), mem_req, 1);
      chk($sformatf("stall_addr_%0d", i), mem_addr, 32'h20);
      chk($sformatf("stall_ack_%0d", i), m0_ack, 0);
    end
    mem_ready = 1; mem_rdata = 32'h12345678;
    step();
    chk("stall_ack", m0_ack, 1);
    chk("stall_rdata", m0_rdata, 32'h12345678);
    m0_req = 0;
    step();
    chk("stall_single_ack", m0_ack, 0);

    // reset while master 1 is being served
    mem_ready = 0;
    m1_req = 1; m1_addr = 32'h30;
    step();
    chk("rb_busy", mem_req, 1);
    rst = 0;
    #1;
    chk("rb_mem_req", mem_req, 0);
    chk("rb_mem_addr", mem_addr, 0);
    chk("rb_m0_rdata", m0_rdata, 0);
    chk("rb_m1_ack", m1_ack, 0);
    m1_req = 0; mem_ready = 1;
    step();
    rst = 1;
    step();
    chk("rb_no_ack_a", m1_ack, 0);
    step();
    chk("rb_no_ack_b", {m1_ack, mem_req}, 0);
    mem_rdata = 32'hCAFEF00D;
    m1_req = 1; m1_addr = 32'h34;
    step();
    chk("rb_new_req", mem_req, 1);
    chk("rb_new_addr", mem_addr, 32'h34);
    step();
    chk("rb_new_ack", m1_ack, 1);
    chk("rb_new_rdata", m1_rdata, 32'hCAFEF00D);
    m1_req = 0;
    step();

    // starvation guard: contested rounds, master 1 withdraws when it loses
    m0_addr = 32'h100; m1_addr = 32'h200;
    for (int r = 0; r < 11; r++) begin
      m0_req = 1;
      m1_req = !rnd_solo[r];
      step();
      m0_req = 0; m1_req = 0;
      step();
      chk($sformatf("starve_r%0d_m0", r), m0_ack, !rnd_win1[r]);
      chk($sformatf("starve_r%0d_m1", r), m1_ack, rnd_win1[r]);
      step();
    end

`ifdef DMEM_ARB_STATS_EN
    chk("stats_gnt0", gnt0_cnt, 9);
    chk("stats_gnt1", gnt1_cnt, 3);
    chk("stats_contest", contest_cnt, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
